// File: rtl/memory_addr_bridge_spec_pkg.sv
// Shared constants and sequencer state type for the camera-to-SRAM address bridge.
package memory_addr_bridge_spec_pkg;
    localparam int ADDR_W        = 16;
    localparam int WE_LOW_CYCLES = 2;
    localparam int CNT_W         = $clog2(WE_LOW_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD
    } seq_state_t;
endpackage

// File: rtl/memory_addr_bridge_spec_sig_sync.sv
// Two-flop synchronizer for an asynchronous camera signal, with single-cycle
// rising/falling edge pulses derived from the synchronized value.
module sig_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_prev;
    assign o_fall = ~r_s2 & r_prev;
endmodule

// File: rtl/memory_addr_bridge_spec.sv
// Camera byte stream to SRAM write sequencer: one byte-lane write per pclk
// rising edge during an active line, two bytes packed per SRAM word.
//
// state | meaning
// IDLE  | no write; byte enables and WEb deasserted
// SETUP | byte enable asserted, address settled, WEb high
// WRITE | WEb low for WE_LOW_CYCLES clocks
// HOLD  | WEb high again, byte enable held; address advances after a lower byte
module memory_addr_bridge_spec
    import memory_addr_bridge_spec_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                clk,
    input  logic                pclk,
    input  logic                HREF,
    input  logic                VSYNC,
    output logic                xclk,
    output logic                WEb,
    output logic                BHEb,
    output logic                BLEb,
    output logic [P_ADDR_W-1:0] SRAM_address,
    input  logic                rst
);
    logic w_pclk_q, w_pclk_rise, w_pclk_fall;
    logic w_href_q, w_href_rise, w_href_fall;
    logic w_vsync_q, w_vsync_rise, w_vsync_fall;
    logic w_unused;
    logic w_byte_evt;

    seq_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_phase;
    logic                r_cur_lower;
    logic                r_xclk;
    logic [P_ADDR_W-1:0] r_addr;

    sig_sync u_sync_pclk (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (pclk),
        .o_q   (w_pclk_q),
        .o_rise(w_pclk_rise),
        .o_fall(w_pclk_fall)
    );

    sig_sync u_sync_href (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (HREF),
        .o_q   (w_href_q),
        .o_rise(w_href_rise),
        .o_fall(w_href_fall)
    );

    sig_sync u_sync_vsync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (VSYNC),
        .o_q   (w_vsync_q),
        .o_rise(w_vsync_rise),
        .o_fall(w_vsync_fall)
    );

    assign w_unused = ^{w_pclk_q, w_pclk_fall, w_href_rise, w_vsync_rise, w_vsync_fall};

    // Events arriving mid-write are dropped; the clock ratio keeps this from happening.
    assign w_byte_evt = w_pclk_rise & w_href_q & ~w_vsync_q & (r_state == IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_byte_evt) w_state_nxt = SETUP;
            end
            SETUP: begin
                w_state_nxt = WRITE;
                w_cnt_nxt   = CNT_W'(WE_LOW_CYCLES - 1);
            end
            WRITE: begin
                if (r_cnt == '0) w_state_nxt = HOLD;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            HOLD: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_cur_lower <= 1'b0;
            r_xclk      <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_xclk  <= ~r_xclk;

            if (w_byte_evt) r_cur_lower <= r_phase;

            if (w_vsync_q || w_href_fall) r_phase <= 1'b0;
            else if (w_byte_evt)          r_phase <= ~r_phase;

            // Frame-blank clear waits for idle so an in-flight write keeps its address.
            if (r_state == HOLD && r_cur_lower)       r_addr <= r_addr + 1'b1;
            else if (w_vsync_q && r_state == IDLE)    r_addr <= '0;
        end
    end

    assign xclk         = r_xclk;
    assign WEb          = (r_state != WRITE);
    assign BHEb         = (r_state == IDLE) | r_cur_lower;
    assign BLEb         = (r_state == IDLE) | ~r_cur_lower;
    assign SRAM_address = r_addr;
endmodule

// File: tb/tb_memory_addr_bridge_spec.sv
// Bench for the camera-to-SRAM bridge: a byte-level model predicts every SRAM
// write, a monitor captures the observed write windows, and the main thread compares.
module tb_memory_addr_bridge_spec;
    logic        clk = 1'b0;
    logic        rst, pclk, HREF, VSYNC;
    logic        xclk, WEb, BHEb, BLEb;
    logic [15:0] SRAM_address;
    logic        xclk_w, web_w, bheb_w, bleb_w;
    logic [3:0]  addr_w;

    always #5 clk = ~clk;

    memory_addr_bridge_spec dut (
        .clk(clk), .pclk(pclk), .HREF(HREF), .VSYNC(VSYNC), .xclk(xclk),
        .WEb(WEb), .BHEb(BHEb), .BLEb(BLEb), .SRAM_address(SRAM_address), .rst(rst)
    );

    // Narrow-address copy lets the wrap boundary be reached in a short run.
    memory_addr_bridge_spec #(.P_ADDR_W(4)) dut_w (
        .clk(clk), .pclk(pclk), .HREF(HREF), .VSYNC(VSYNC), .xclk(xclk_w),
        .WEb(web_w), .BHEb(bheb_w), .BLEb(bleb_w), .SRAM_address(addr_w), .rst(rst)
    );

    typedef struct { logic [15:0] addr; logic lower; } exp_t;
    typedef struct { logic [15:0] addr; logic [3:0] addr_w; logic lower;
                     logic [7:0] pat; int len; bit ok; } obs_t;
    typedef struct { bit frame_rst; bit vs; int nbytes; int exp_up; int exp_lo;
                     logic [15:0] exp_addr; logic [3:0] exp_addr_w; } vec_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   stray = 0;

    logic [15:0] m_addr;
    logic        m_phase;

    obs_t cur;
    bit   mon_act = 1'b0;

    always @(negedge clk) begin
        if (!mon_act) begin
            if (BHEb === 1'b0 || BLEb === 1'b0) begin
                mon_act    = 1'b1;
                cur.addr   = SRAM_address;
                cur.addr_w = addr_w;
                cur.lower  = (BLEb === 1'b0);
                cur.pat    = {7'b0, WEb};
                cur.len    = 1;
                cur.ok     = (BHEb !== BLEb) && (web_w === WEb) && (bheb_w === BHEb) &&
                             (bleb_w === BLEb) && (xclk_w === xclk);
            end
        end else if (BHEb === 1'b1 && BLEb === 1'b1) begin
            obs_q.push_back(cur);
            mon_act = 1'b0;
        end else begin
            cur.pat = {cur.pat[6:0], WEb};
            cur.len = cur.len + 1;
            if (SRAM_address !== cur.addr || addr_w !== cur.addr_w ||
                (BLEb === 1'b0) !== cur.lower || BHEb === BLEb ||
                web_w !== WEb || bheb_w !== BHEb || bleb_w !== BLEb || xclk_w !== xclk)
                cur.ok = 1'b0;
        end
        if (WEb === 1'b0 && BHEb === 1'b1 && BLEb === 1'b1) stray = stray + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pclk_cycle();
        exp_t e;
        pclk = 1'b1;
        if (HREF && !VSYNC) begin
            e.addr  = m_addr;
            e.lower = m_phase;
            exp_q.push_back(e);
            if (m_phase) m_addr = m_addr + 16'd1;
            m_phase = ~m_phase;
        end
        repeat (3) @(negedge clk);
        pclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_href(input logic v);
        if (HREF && !v) m_phase = 1'b0;
        HREF = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_vsync(input logic v);
        if (v) begin
            m_addr  = 16'd0;
            m_phase = 1'b0;
        end
        VSYNC = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string tag, output int ups, output int los);
        exp_t e;
        obs_t o;
        int   n;
        ups = 0;
        los = 0;
        repeat (12) @(negedge clk);
        chk({tag, "_write_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_wr_addr"},   o.addr, e.addr);
            chk({tag, "_wr_addr4"},  o.addr_w, e.addr[3:0]);
            chk({tag, "_wr_lane"},   o.lower, e.lower);
            chk({tag, "_we_shape"},  {o.len[7:0], o.pat}, 16'h0409);
            chk({tag, "_wr_stable"}, o.ok, 1'b1);
            if (o.lower) los++;
            else         ups++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    vec_t vecs[7];
    int   ups, los, r;
    bit   got;
    logic exp_x;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1280, 640, 640, 16'd640, 4'd0};
        vecs[1] = '{1'b0, 1'b0, 3,    2,   1,   16'd641, 4'd1};
        vecs[2] = '{1'b0, 1'b0, 2,    1,   1,   16'd642, 4'd2};
        vecs[3] = '{1'b0, 1'b1, 4,    0,   0,   16'd0,   4'd0};
        vecs[4] = '{1'b1, 1'b0, 1,    1,   0,   16'd0,   4'd0};
        vecs[5] = '{1'b0, 1'b0, 5,    3,   2,   16'd2,   4'd2};
        vecs[6] = '{1'b1, 1'b0, 34,   17,  17,  16'd17,  4'd1};

        rst = 1'b1; pclk = 1'b0; HREF = 1'b0; VSYNC = 1'b0;
        m_addr = 16'd0; m_phase = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_xclk", xclk, 1'b0);
        chk("rst_web", WEb, 1'b1);
        chk("rst_bheb", BHEb, 1'b1);
        chk("rst_bleb", BLEb, 1'b1);
        chk("rst_addr", SRAM_address, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_x = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_x = ~exp_x;
            chk("xclk_toggle", xclk, exp_x);
        end
        repeat (4) pclk_cycle();
        drain("idle", ups, los);
        chk("idle_writes", ups + los, 0);
        chk("idle_web", WEb, 1'b1);
        chk("idle_addr", SRAM_address, 16'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].frame_rst) begin
                set_vsync(1'b1);
                repeat (6) @(negedge clk);
                set_vsync(1'b0);
            end
            if (vecs[i].vs) set_vsync(1'b1);
            set_href(1'b1);
            repeat (vecs[i].nbytes) pclk_cycle();
            set_href(1'b0);
            drain($sformatf("row%0d", i), ups, los);
            chk($sformatf("row%0d_upper", i), ups, vecs[i].exp_up);
            chk($sformatf("row%0d_lower", i), los, vecs[i].exp_lo);
            chk($sformatf("row%0d_addr", i), SRAM_address, vecs[i].exp_addr);
            chk($sformatf("row%0d_addr4", i), addr_w, vecs[i].exp_addr_w);
            if (vecs[i].vs) set_vsync(1'b0);
        end

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      set_vsync(~VSYNC);
            else if (r <= 2) set_href(~HREF);
            else if (r == 3) repeat ($urandom_range(1, 5)) @(negedge clk);
            else             pclk_cycle();
            if (i % 50 == 49) begin
                drain("rand", ups, los);
                chk("rand_addr", SRAM_address, m_addr);
                chk("rand_addr4", addr_w, m_addr[3:0]);
            end
        end

        set_href(1'b0);
        set_vsync(1'b1);
        set_vsync(1'b0);
        set_href(1'b1);
        repeat (3) pclk_cycle();
        drain("pre_abort", ups, los);
        chk("pre_abort_addr", SRAM_address, 16'd1);
        pclk = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (WEb === 1'b0) got = 1'b1;
        end
        chk("abort_we_seen", got, 1'b1);
        rst = 1'b1;
        pclk = 1'b0;
        HREF = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_web", WEb, 1'b1);
        chk("abort_bheb", BHEb, 1'b1);
        chk("abort_bleb", BLEb, 1'b1);
        chk("abort_addr", SRAM_address, 16'd0);
        chk("abort_xclk", xclk, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        m_addr = 16'd0;
        m_phase = 1'b0;
        set_href(1'b1);
        repeat (2) pclk_cycle();
        set_href(1'b0);
        drain("post_abort", ups, los);
        chk("post_abort_addr", SRAM_address, 16'd1);
        chk("stray_we", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/memory_addr_bridge_spec.md
MEMORY_ADDR_BRIDGE_SPEC -- requirements
Module: MemoryaddrBridge

Interface
REQ-001 The block SHALL have one clock, clk, and one synchronous, active-high reset, rst; every register is updated on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock; its frequency SHALL be at least 6x the pclk frequency.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port pclk, input, 1 bit: camera pixel clock, sampled as data (not used as a clock).
REQ-005 Port HREF, input, 1 bit: camera line-valid, active high.
REQ-006 Port VSYNC, input, 1 bit: camera frame sync, active high (blanking).
REQ-007 Port xclk, output, 1 bit: camera master clock, clk/2.
REQ-008 Port WEb, output, 1 bit: SRAM write enable, active low.
REQ-009 Port BHEb, output, 1 bit: SRAM upper-byte enable, active low.
REQ-010 Port BLEb, output, 1 bit: SRAM lower-byte enable, active low.
REQ-011 Port SRAM_address, output, 16 bits: SRAM word address.
REQ-012 Port order SHALL be: clk, pclk, HREF, VSYNC, xclk, WEb, BHEb, BLEb, SRAM_address, rst.

Function
REQ-013 xclk SHALL toggle every clk cycle.
REQ-014 pclk, HREF and VSYNC SHALL each pass through a 2-FF synchronizer; the rising edge of pclk is detected on the synchronized signal.
REQ-015 A byte event is a detected pclk rising edge while synchronized HREF=1 and synchronized VSYNC=0.
REQ-016 Byte phase register: phase 0 means upper byte, phase 1 means lower byte; it toggles on each byte event.
REQ-017 Write sequence per byte event at detect cycle N: cycle N+1 drives the byte enable (phase 0: BHEb=0, BLEb=1; phase 1: BHEb=1, BLEb=0) with WEb=1.
REQ-018 Cycles N+2 and N+3 SHALL drive WEb=0 with the byte enables and SRAM_address held.
REQ-019 Cycle N+4 SHALL drive WEb=1 with the byte enables still held; both byte enables return to 1 at N+5.
REQ-020 SRAM_address SHALL be stable whenever WEb=0 and whenever a byte enable is 0.
REQ-021 SRAM_address SHALL increment by 1 at cycle N+5 of a phase-1 (lower-byte) write only, giving one word per 2 bytes.
REQ-022 SRAM_address SHALL wrap from 0xFFFF to 0x0000.
REQ-023 While synchronized VSYNC=1, SRAM_address and the byte phase SHALL be held at 0 and no write starts; any write already in progress completes first.
REQ-024 On a synchronized HREF falling edge, the byte phase SHALL reset to 0; an unpaired upper byte is left written and the address is not incremented.
REQ-025 A byte event that arrives while a write sequence is active SHALL be ignored; with a legal clk:pclk ratio this cannot occur.
REQ-026 When idle, outputs SHALL be WEb=1, BHEb=1, BLEb=1.

Reset
REQ-027 While rst=1: xclk=0, WEb=1, BHEb=1, BLEb=1, SRAM_address=0, byte phase=0, synchronizers=0, write sequencer idle.
REQ-028 Reset asserted mid-write SHALL abort the write at the next clk edge with all outputs taking their reset values.

Structure
REQ-029 A shared package SHALL hold ADDR_W=16, WE_LOW_CYCLES=2, and the sequencer state enum (IDLE, SETUP, WRITE, HOLD).
REQ-030 One sub-module, sig_sync, SHALL be instantiated three times; it provides the 2-FF synchronizer plus rising- and falling-edge pulse outputs.

Verification
REQ-031 Reset then idle: rst held 4 cycles, then pclk toggling with HREF=0 -> WEb=BHEb=BLEb=1, SRAM_address=0, xclk toggles each cycle.
REQ-032 One line: VSYNC=0, HREF=1 for 1280 pclk rising edges -> 1280 WEb low pulses of 2 clk each, alternating BHEb/BLEb, SRAM_address ends at 640.
REQ-033 Frame reset: address at 640, VSYNC pulse high -> SRAM_address=0 and no WEb pulses during VSYNC=1.
REQ-034 Odd line: HREF high for 3 pclk edges -> writes to upper, lower, upper; address increments once; next line starts on phase 0 at the next address.
REQ-035 Wrap: preload by streaming 131072 bytes -> SRAM_address returns to 0x0000 after 0xFFFF.
REQ-036 Reset mid-write: rst asserted while WEb=0 -> the next cycle gives WEb=1, BHEb=BLEb=1, SRAM_address=0.
